// File: rtl/usb_pd_phy_tx.sv
// USB PD PHY transmitter: captures a message on start and sends preamble, SOP, header, data
// objects, CRC32 and EOP on the CC line, 4b5b-encoded and then BMC-encoded at 300 kbps.
module usb_pd_phy_tx #(
  parameter int unsigned SystemKhz = 200000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_tx_role,
  input  logic [2:0]  i_msg_id,
  input  logic [2:0]  i_msg_num,
  input  logic [3:0]  i_msg_type,
  input  logic [31:0] i_msg_word0,
  input  logic [31:0] i_msg_word1,
  input  logic [31:0] i_msg_word2,
  input  logic [31:0] i_msg_word3,
  input  logic [31:0] i_msg_word4,
  input  logic [31:0] i_msg_word5,
  input  logic [31:0] i_msg_word6,
  output logic        o_bmc_out,
  output logic        o_bmc_oe,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned HalfBit = SystemKhz / 600;
  localparam int unsigned HcW     = $clog2(HalfBit);
  localparam logic [4:0]  Sync1   = 5'b11000;
  localparam logic [4:0]  Sync2   = 5'b10001;
  localparam logic [4:0]  EopK    = 5'b01101;

  typedef enum logic [3:0] {
    StIdle, StPreamble, StSop, StHeader, StData, StCrc, StEop, StTail, StDone
  } state_e;

  state_e         r_state, w_next_state;
  logic [HcW-1:0] r_hcnt;
  logic           r_half;
  logic [2:0]     r_bit;
  logic [5:0]     r_cnt;
  logic [2:0]     r_word_idx;
  logic [15:0]    r_hdr;
  logic [2:0]     r_num;
  logic [31:0]    r_words [7];
  logic [31:0]    r_crc;
  logic [4:0]     r_crc_cnt;
  logic           r_line;

  logic        w_accept, w_half_end, w_bit_end, w_sym_end, w_field_end, w_last_word, w_cur_bit;
  logic [4:0]  w_sym, w_crc_len, w_crc_j;
  logic [31:0] w_word, w_crc_word, w_crc_out;
  logic [7:0]  w_crc_byte;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;  4'h2: return 5'b10100;
      4'h3: return 5'b10101;  4'h4: return 5'b01010;  4'h5: return 5'b01011;
      4'h6: return 5'b01110;  4'h7: return 5'b01111;  4'h8: return 5'b10010;
      4'h9: return 5'b10011;  4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;  4'hE: return 5'b11100;
      default: return 5'b11101;
    endcase
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_accept    = (r_state == StIdle) && i_start;
  assign w_half_end  = (r_hcnt == HcW'(HalfBit - 1));
  assign w_bit_end   = w_half_end && r_half;
  assign w_sym_end   = w_bit_end && (r_bit == 3'd4);
  assign w_last_word = ((r_word_idx + 3'd1) == r_num);
  assign w_crc_out   = ~r_crc;
  assign w_crc_len   = 5'd2 + {r_num, 2'b00};
  assign w_crc_j     = r_crc_cnt - 5'd2;

  always_comb begin
    w_word     = '0;
    w_crc_word = '0;
    if (r_word_idx != 3'd7) w_word = r_words[r_word_idx];
    if (w_crc_j[4:2] != 3'd7) w_crc_word = r_words[w_crc_j[4:2]];
    if (r_crc_cnt == 5'd0)      w_crc_byte = r_hdr[7:0];
    else if (r_crc_cnt == 5'd1) w_crc_byte = r_hdr[15:8];
    else                        w_crc_byte = w_crc_word[{w_crc_j[1:0], 3'b000} +: 8];
  end

  always_comb begin
    w_sym       = '0;
    w_field_end = 1'b0;
    case (r_state)
      StPreamble: w_field_end = w_bit_end && (r_cnt == 6'd63);
      StSop: begin
        w_sym       = (r_cnt[1:0] == 2'd3) ? Sync2 : Sync1;
        w_field_end = w_sym_end && (r_cnt == 6'd3);
      end
      StHeader: begin
        w_sym       = enc4b5b(r_hdr[{r_cnt[1:0], 2'b00} +: 4]);
        w_field_end = w_sym_end && (r_cnt == 6'd3);
      end
      StData: begin
        w_sym       = enc4b5b(w_word[{r_cnt[2:0], 2'b00} +: 4]);
        w_field_end = w_sym_end && (r_cnt == 6'd7);
      end
      StCrc: begin
        w_sym       = enc4b5b(w_crc_out[{r_cnt[2:0], 2'b00} +: 4]);
        w_field_end = w_sym_end && (r_cnt == 6'd7);
      end
      StEop: begin
        w_sym       = EopK;
        w_field_end = w_sym_end;
      end
      default: ;
    endcase
    w_cur_bit = (r_state == StPreamble) ? r_cnt[0] : w_sym[r_bit];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:     if (i_start) w_next_state = StPreamble;
      StPreamble: if (w_field_end) w_next_state = StSop;
      StSop:      if (w_field_end) w_next_state = StHeader;
      StHeader:   if (w_field_end) w_next_state = (r_num != 3'd0) ? StData : StCrc;
      StData:     if (w_field_end && w_last_word) w_next_state = StCrc;
      StCrc:      if (w_field_end) w_next_state = StEop;
      StEop:      if (w_field_end) w_next_state = StTail;
      StTail:     if (w_half_end) w_next_state = StDone;
      StDone:     w_next_state = StIdle;
      default:    w_next_state = StIdle;
    endcase
  end

  always_comb begin
    o_bmc_out = r_line;
    o_bmc_oe  = (r_state != StIdle) && (r_state != StDone);
    o_busy    = (r_state != StIdle) && (r_state != StDone);
    o_done    = (r_state == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) begin
      r_hdr      <= {1'b0, i_msg_num, i_msg_id, i_tx_role, 2'b01, 1'b0, 1'b0, i_msg_type};
      r_num      <= i_msg_num;
      r_words[0] <= i_msg_word0;
      r_words[1] <= i_msg_word1;
      r_words[2] <= i_msg_word2;
      r_words[3] <= i_msg_word3;
      r_words[4] <= i_msg_word4;
      r_words[5] <= i_msg_word5;
      r_words[6] <= i_msg_word6;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == StIdle)) begin
      r_hcnt     <= '0;
      r_half     <= 1'b0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_word_idx <= '0;
      r_crc      <= '1;
      r_crc_cnt  <= '0;
      // Idle level is 0, so accepting a packet is the first preamble toggle.
      r_line     <= !i_rst && w_accept;
    end else begin
      if ((r_state == StPreamble) && (r_crc_cnt < w_crc_len)) begin
        r_crc     <= crc32_byte(r_crc, w_crc_byte);
        r_crc_cnt <= r_crc_cnt + 5'd1;
      end
      r_hcnt <= w_half_end ? '0 : r_hcnt + 1'b1;
      if (w_half_end) begin
        r_half <= ~r_half;
        if (!r_half) begin
          if (w_cur_bit && (r_state != StTail)) r_line <= ~r_line;
        end else begin
          // The EOP's last bit is followed by a low tail, not a new bit.
          if ((r_state == StEop) && w_sym_end) r_line <= 1'b0;
          else                                 r_line <= ~r_line;
          if (r_state == StPreamble) begin
            r_cnt <= w_field_end ? '0 : r_cnt + 6'd1;
          end else begin
            r_bit <= (r_bit == 3'd4) ? 3'd0 : r_bit + 3'd1;
            if (w_sym_end) r_cnt <= w_field_end ? '0 : r_cnt + 6'd1;
            if ((r_state == StData) && w_field_end) r_word_idx <= r_word_idx + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_pd_phy_tx.sv
// Bench for usb_pd_phy_tx: expected symbols are queued at launch, the line is recorded and
// BMC-decoded on the bench's own bit grid, then popped and compared symbol by symbol.
module tb_usb_pd_phy_tx;

  localparam int unsigned Khz  = 6000;
  localparam int unsigned H    = Khz / 600;
  localparam int unsigned NoGl = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, role;
  logic [2:0]  id, num;
  logic [3:0]  typ;
  logic [31:0] words [7];
  logic        bmc_out, bmc_oe, busy, done;

  typedef struct {
    logic [7:0]  v;
    int unsigned w;
    string       tag;
  } item_t;

  item_t exp_q[$];
  logic  lv_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  usb_pd_phy_tx #(.SystemKhz(Khz)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_role(role), .i_msg_id(id),
    .i_msg_num(num), .i_msg_type(typ),
    .i_msg_word0(words[0]), .i_msg_word1(words[1]), .i_msg_word2(words[2]),
    .i_msg_word3(words[3]), .i_msg_word4(words[4]), .i_msg_word5(words[5]),
    .i_msg_word6(words[6]),
    .o_bmc_out(bmc_out), .o_bmc_oe(bmc_oe), .o_busy(busy), .o_done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;  4'h2: return 5'b10100;
      4'h3: return 5'b10101;  4'h4: return 5'b01010;  4'h5: return 5'b01011;
      4'h6: return 5'b01110;  4'h7: return 5'b01111;  4'h8: return 5'b10010;
      4'h9: return 5'b10011;  4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;  4'hE: return 5'b11100;
      default: return 5'b11101;
    endcase
  endfunction

  // Non-reflected MSB-first CRC-32 on bit-reversed bytes.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_final(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  task automatic push_item(input logic [7:0] v, input int unsigned w, input string tag);
    item_t it;
    it.v = v;
    it.w = w;
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  task automatic push_packet(input logic r, input logic [2:0] i_d, input logic [2:0] n,
                             input logic [3:0] t);
    logic [15:0] hdr;
    logic [31:0] crc;
    hdr = {1'b0, n, i_d, r, 2'b01, 1'b0, 1'b0, t};
    for (int k = 0; k < 8; k++) push_item(8'hAA, 8, "preamble");
    for (int k = 0; k < 3; k++) push_item(8'h18, 5, "sync1");
    push_item(8'h11, 5, "sync2");
    for (int k = 0; k < 4; k++) push_item({3'b000, enc(hdr[4*k +: 4])}, 5, "header");
    crc = crc_step(32'hFFFF_FFFF, hdr[7:0]);
    crc = crc_step(crc, hdr[15:8]);
    for (int wi = 0; wi < int'(n); wi++) begin
      for (int by = 0; by < 4; by++) crc = crc_step(crc, words[wi][8*by +: 8]);
      for (int k = 0; k < 8; k++) push_item({3'b000, enc(words[wi][4*k +: 4])}, 5, "data");
    end
    crc = crc_final(crc);
    for (int k = 0; k < 8; k++) push_item({3'b000, enc(crc[4*k +: 4])}, 5, "crc");
    push_item(8'h0D, 5, "eop");
  endtask

  // Start a packet; inputs are scrambled afterwards since the DUT must have captured them.
  task automatic launch(input logic r, input logic [2:0] i_d, input logic [2:0] n,
                        input logic [3:0] t, input bit expect_it);
    role = r; id = i_d; num = n; typ = t;
    if (expect_it) push_packet(r, i_d, n, t);
    start = 1'b1;
    tick();
    start = 1'b0;
    role = 1'($urandom); id = 3'($urandom); num = 3'($urandom); typ = 4'($urandom);
    for (int i = 0; i < 7; i++) words[i] = $urandom;
  endtask

  task automatic run_packet(input int unsigned nw, input int unsigned glitch_c);
    int unsigned bits, total, oe_cnt, done_cnt, bad_tog, bad_edge, bad_tail;
    logic        a, b, prev;
    logic [7:0]  val;
    logic        bitq[$];
    item_t       it;
    bits = 149 + 40 * nw;
    total = bits * 2 * H + H;
    oe_cnt = 0; done_cnt = 0; bad_tog = 0; bad_edge = 0; bad_tail = 0;
    lv_q.delete();
    check("first_cycle", 64'({busy, bmc_oe, bmc_out}), 64'(3'b111));
    for (int unsigned c = 0; c <= total; c++) begin
      lv_q.push_back(bmc_out);
      if (bmc_oe) oe_cnt++;
      if (done) done_cnt++;
      if (c == total) check("done_cycle", 64'({done, busy, bmc_oe}), 64'(3'b100));
      start = (c == glitch_c);
      if (c == glitch_c) begin
        role = ~role; id = id + 3'd1; num = 3'd5; typ = 4'hF; words[0] = 32'hDEAD_BEEF;
      end
      tick();
    end
    start = 1'b0;
    check("idle_after_done", 64'({busy, done, bmc_oe}), 64'(0));
    check("oe_width", 64'(oe_cnt), 64'(total));
    check("done_count", 64'(done_cnt), 64'(1));
    prev = 1'b0;
    for (int unsigned k = 0; k < bits; k++) begin
      a = lv_q[2*H*k + H/2];
      b = lv_q[2*H*k + H + H/2];
      if (a == prev) bad_tog++;
      bitq.push_back(a ^ b);
      prev = b;
    end
    check("bit_start_toggle", 64'(bad_tog), 64'(0));
    for (int unsigned c = 1; c < total; c++)
      if ((lv_q[c] != lv_q[c-1]) && (c % H != 0)) bad_edge++;
    check("edge_grid", 64'(bad_edge), 64'(0));
    for (int unsigned c = 2 * H * bits; c < total; c++) if (lv_q[c]) bad_tail++;
    check("tail_low", 64'(bad_tail), 64'(0));
    while (exp_q.size() != 0) begin
      it = exp_q.pop_front();
      val = '0;
      for (int unsigned k = 0; k < it.w; k++) val[k] = (bitq.size() != 0) ? bitq.pop_front() : 1'bx;
      check(it.tag, 64'(val), 64'(it.v));
    end
    check("stream_length", 64'(bitq.size()), 64'(0));
  endtask

  initial begin
    int mids;
    rst = 1'b1; start = 1'b0; role = 1'b0; id = '0; num = '0; typ = '0;
    for (int i = 0; i < 7; i++) words[i] = '0;
    repeat (3) tick();
    check("reset_outputs", 64'({bmc_out, bmc_oe, busy, done}), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_outputs", 64'({bmc_out, bmc_oe, busy, done}), 64'(0));

    // GoodCRC; header nibble 3 is 0x0, whose code has four 1 bits and one 0 bit.
    launch(1'b1, 3'd3, 3'd0, 4'h1, 1'b1);
    run_packet(0, NoGl);
    mids = 0;
    for (int unsigned k = 99; k < 104; k++) if (lv_q[2*H*k + H] != lv_q[2*H*k + H - 1]) mids++;
    check("zero_nibble_mid_toggles", 64'(mids), 64'(4));

    // Request with one data object.
    words[0] = 32'h1304_B12C;
    launch(1'b0, 3'd2, 3'd1, 4'h2, 1'b1);
    run_packet(1, NoGl);

    // Seven distinct data objects.
    for (int i = 0; i < 7; i++) words[i] = 32'h1111_1111 * (i + 1);
    launch(1'b1, 3'd5, 3'd7, 4'h3, 1'b1);
    run_packet(7, NoGl);

    // Start with different fields 1000 cycles in is ignored; a start right after done is taken.
    words[0] = 32'hA5A5_0F0F; words[1] = 32'h0123_4567;
    launch(1'b0, 3'd1, 3'd2, 4'h6, 1'b1);
    run_packet(2, 1000);
    launch(1'b1, 3'd4, 3'd0, 4'h1, 1'b1);
    run_packet(0, NoGl);

    // Reset in the middle of the first data object abandons the packet.
    launch(1'b0, 3'd6, 3'd3, 4'h4, 1'b0);
    repeat (2500) tick();
    check("pre_reset_busy", 64'({busy, bmc_oe}), 64'(2'b11));
    rst = 1'b1;
    tick();
    check("reset_abort", 64'({bmc_oe, bmc_out, busy, done}), 64'(0));
    rst = 1'b0;
    tick();
    check("after_abort_idle", 64'({bmc_oe, bmc_out, busy, done}), 64'(0));
    words[0] = 32'hCAFE_F00D; words[1] = 32'h8000_0001; words[2] = 32'h7E7E_1234;
    launch(1'b0, 3'd6, 3'd3, 4'h4, 1'b1);
    run_packet(3, NoGl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
